// File: rtl/loop_nonoverlap_ctrl_if.sv
// Gate-drive handshake bundle for loop_nonoverlap_ctrl: command/feedback inputs
// and registered gate, fault and state outputs.
interface loop_nonoverlap_ctrl_if;
  logic       en_i;
  logic       pwm_i;
  logic       hs_sns_i;
  logic       ls_sns_i;
  logic       hs_o;
  logic       ls_o;
  logic       fault_o;
  logic [2:0] state_o;

  modport master (
    output en_i, pwm_i, hs_sns_i, ls_sns_i,
    input  hs_o, ls_o, fault_o, state_o
  );

  modport slave (
    input  en_i, pwm_i, hs_sns_i, ls_sns_i,
    output hs_o, ls_o, fault_o, state_o
  );
endinterface

// File: rtl/loop_nonoverlap_ctrl.sv
// Half-bridge non-overlap controller with enforced dead time between gate phases.
// Optional macro LOOP_SENSE_CHECK_EN adds gate-feedback checks and a sticky FAULT state.
module loop_nonoverlap_ctrl #(
  parameter int DEAD_CYC = 4,
  parameter int SNS_TMO  = 16
) (
  input  logic                    CELCLK,
  input  logic                    CELRST,
  input  logic                    CELV,
  input  logic                    CELG,
  input  logic                    SUB,
  loop_nonoverlap_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LS_ON = 3'd1,
    DT_LH = 3'd2,
    HS_ON = 3'd3,
    DT_HL = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam int         DEAD_EFF = (DEAD_CYC < 1) ? 1 : DEAD_CYC;
  localparam logic [7:0] DEAD_LIM = 8'(DEAD_EFF);
  localparam logic [7:0] TMO_LIM  = 8'(SNS_TMO);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic [7:0] cnt_inc_s;
  logic       dt_done_s;
  logic       hs_r;
  logic       ls_r;
  logic       fault_r;

  logic       lh_ok_s;
  logic       hl_ok_s;
  logic       tmo_s;
  logic       hs_flt_s;
  logic       ls_flt_s;
  logic       fault_stay_s;
  logic       unused_s;

`ifdef LOOP_SENSE_CHECK_EN
  // The opposite gate must be confirmed low before the next one is turned on.
  assign lh_ok_s      = ~bus.ls_sns_i;
  assign hl_ok_s      = ~bus.hs_sns_i;
  assign tmo_s        = (cnt_r >= TMO_LIM);
  assign hs_flt_s     = bus.hs_sns_i;
  assign ls_flt_s     = bus.ls_sns_i;
  assign fault_stay_s = 1'b1;
  assign unused_s     = &{1'b0, CELV, CELG, SUB};
`else
  assign lh_ok_s      = 1'b1;
  assign hl_ok_s      = 1'b1;
  assign tmo_s        = 1'b0;
  assign hs_flt_s     = 1'b0;
  assign ls_flt_s     = 1'b0;
  assign fault_stay_s = 1'b0;
  assign unused_s     = &{1'b0, CELV, CELG, SUB, bus.hs_sns_i, bus.ls_sns_i, TMO_LIM};
`endif

  assign cnt_inc_s = (cnt_r == 8'd255) ? 8'd255 : (cnt_r + 8'd1);
  assign dt_done_s = (cnt_r >= DEAD_LIM);

  // Next-state logic; the counter stays at zero outside dead-time phases.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = 8'd0;
    if (!bus.en_i && (state_r != FAULT)) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.en_i) state_nxt_s = LS_ON;
          else          state_nxt_s = IDLE;
        end
        LS_ON: begin
          if (hs_flt_s)       state_nxt_s = FAULT;
          else if (bus.pwm_i) state_nxt_s = DT_LH;
          else                state_nxt_s = LS_ON;
        end
        DT_LH: begin
          if (dt_done_s && lh_ok_s) begin
            state_nxt_s = HS_ON;
          end else if (tmo_s) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = DT_LH;
            cnt_nxt_s   = cnt_inc_s;
          end
        end
        HS_ON: begin
          if (ls_flt_s)        state_nxt_s = FAULT;
          else if (!bus.pwm_i) state_nxt_s = DT_HL;
          else                 state_nxt_s = HS_ON;
        end
        DT_HL: begin
          if (dt_done_s && hl_ok_s) begin
            state_nxt_s = LS_ON;
          end else if (tmo_s) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = DT_HL;
            cnt_nxt_s   = cnt_inc_s;
          end
        end
        FAULT: begin
          if (!bus.en_i || !fault_stay_s) state_nxt_s = IDLE;
          else                            state_nxt_s = FAULT;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Gate enables are registered from the next state so they track state_r exactly.
  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      hs_r    <= 1'b0;
      ls_r    <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      hs_r    <= (state_nxt_s == HS_ON);
      ls_r    <= (state_nxt_s == LS_ON);
      fault_r <= fault_stay_s && (state_nxt_s == FAULT);
    end
  end

  assign bus.hs_o    = hs_r;
  assign bus.ls_o    = ls_r;
  assign bus.fault_o = fault_r;
  assign bus.state_o = state_r;

endmodule

// File: tb/tb_loop_nonoverlap_ctrl.sv
// Directed self-checking bench for loop_nonoverlap_ctrl (DEAD_CYC=4, SNS_TMO=16).
module tb_loop_nonoverlap_ctrl;

  logic CELCLK = 1'b0;
  logic CELRST = 1'b1;
  logic CELV   = 1'b1;
  logic CELG   = 1'b0;
  logic SUB    = 1'b0;

  loop_nonoverlap_ctrl_if bus ();

  loop_nonoverlap_ctrl #(.DEAD_CYC(4), .SNS_TMO(16)) dut (
    .CELCLK (CELCLK),
    .CELRST (CELRST),
    .CELV   (CELV),
    .CELG   (CELG),
    .SUB    (SUB),
    .bus    (bus)
  );

  always #5 CELCLK = ~CELCLK;

  int tests = 0;
  int fails = 0;

  // Expected {hs_o, ls_o, fault_o, state_o}
  localparam logic [5:0] V_IDLE = 6'b000000;
  localparam logic [5:0] V_LS   = 6'b010001;
  localparam logic [5:0] V_DTLH = 6'b000010;
  localparam logic [5:0] V_HS   = 6'b100011;
  localparam logic [5:0] V_DTHL = 6'b000100;
  localparam logic [5:0] V_FLT  = 6'b001101;

  function automatic logic [5:0] obs();
    return {bus.hs_o, bus.ls_o, bus.fault_o, bus.state_o};
  endfunction

  task automatic step();
    @(posedge CELCLK);
    #1;
  endtask

  task automatic test_reset();
    CELRST = 1'b1; bus.en_i = 1'b0; bus.pwm_i = 1'b0;
    bus.hs_sns_i = 1'b0; bus.ls_sns_i = 1'b0;
    #12;
    tests++; if (obs() !== V_IDLE) begin fails++; $display("FAIL reset_held got %b want %b", obs(), V_IDLE); end
    @(negedge CELCLK); CELRST = 1'b0;
    step();
    tests++; if (obs() !== V_IDLE) begin fails++; $display("FAIL reset_idle_en0 got %b want %b", obs(), V_IDLE); end
  endtask

  task automatic test_startup();
    bus.en_i = 1'b1; bus.pwm_i = 1'b0;
    step();
    tests++; if (obs() !== V_LS) begin fails++; $display("FAIL startup_ls got %b want %b", obs(), V_LS); end
    step();
    tests++; if (obs() !== V_LS) begin fails++; $display("FAIL ls_hold got %b want %b", obs(), V_LS); end
  endtask

  task automatic test_deadtime_lh();
    bus.pwm_i = 1'b1;
    step();
    tests++; if (obs() !== V_DTLH) begin fails++; $display("FAIL dtlh_entry got %b want %b", obs(), V_DTLH); end
    for (int k = 1; k <= 4; k++) begin
      step();
      tests++; if (obs() !== V_DTLH) begin fails++; $display("FAIL dtlh_cycle%0d got %b want %b", k, obs(), V_DTLH); end
    end
    step();
    tests++; if (obs() !== V_HS) begin fails++; $display("FAIL dtlh_exit got %b want %b", obs(), V_HS); end
  endtask

  task automatic test_dthl_pwm_pulse();
    bus.pwm_i = 1'b0;
    step();
    tests++; if (obs() !== V_DTHL) begin fails++; $display("FAIL dthl_entry got %b want %b", obs(), V_DTHL); end
    for (int k = 1; k <= 4; k++) begin
      bus.pwm_i = (k <= 2) ? 1'b1 : 1'b0;
      step();
      tests++; if (obs() !== V_DTHL) begin fails++; $display("FAIL dthl_pulse%0d got %b want %b", k, obs(), V_DTHL); end
    end
    bus.pwm_i = 1'b0;
    step();
    tests++; if (obs() !== V_LS) begin fails++; $display("FAIL dthl_exit got %b want %b", obs(), V_LS); end
    step();
    tests++; if (obs() !== V_LS) begin fails++; $display("FAIL dthl_no_hs got %b want %b", obs(), V_LS); end
  endtask

  task automatic test_reset_mid_deadtime();
    bus.pwm_i = 1'b1;
    for (int k = 0; k < 3; k++) step();
    tests++; if (obs() !== V_DTLH) begin fails++; $display("FAIL mid_dt_pre got %b want %b", obs(), V_DTLH); end
    #1; CELRST = 1'b1; #1;
    tests++; if (obs() !== V_IDLE) begin fails++; $display("FAIL mid_dt_async got %b want %b", obs(), V_IDLE); end
    step();
    tests++; if (obs() !== V_IDLE) begin fails++; $display("FAIL mid_dt_held got %b want %b", obs(), V_IDLE); end
    @(negedge CELCLK); CELRST = 1'b0; bus.pwm_i = 1'b0;
    step();
    tests++; if (obs() !== V_LS) begin fails++; $display("FAIL mid_dt_restart got %b want %b", obs(), V_LS); end
  endtask

  task automatic test_en_drop();
    bus.pwm_i = 1'b1;
    for (int k = 0; k < 6; k++) step();
    tests++; if (obs() !== V_HS) begin fails++; $display("FAIL en_drop_pre got %b want %b", obs(), V_HS); end
    bus.en_i = 1'b0;
    step();
    tests++; if (obs() !== V_IDLE) begin fails++; $display("FAIL en_drop_hs got %b want %b", obs(), V_IDLE); end
    bus.en_i = 1'b1;
    step();
    tests++; if (obs() !== V_LS) begin fails++; $display("FAIL en_restore got %b want %b", obs(), V_LS); end
    step();
    tests++; if (obs() !== V_DTLH) begin fails++; $display("FAIL en_drop_dt_pre got %b want %b", obs(), V_DTLH); end
    bus.en_i = 1'b0;
    step();
    tests++; if (obs() !== V_IDLE) begin fails++; $display("FAIL en_drop_dt got %b want %b", obs(), V_IDLE); end
    bus.en_i = 1'b1; bus.pwm_i = 1'b0;
    step();
    tests++; if (obs() !== V_LS) begin fails++; $display("FAIL en_restore2 got %b want %b", obs(), V_LS); end
  endtask

`ifdef LOOP_SENSE_CHECK_EN
  task automatic test_sense_wait();
    bus.pwm_i = 1'b1; bus.ls_sns_i = 1'b1;
    step();
    for (int k = 1; k <= 7; k++) begin
      step();
      tests++; if (obs() !== V_DTLH) begin fails++; $display("FAIL sns_wait%0d got %b want %b", k, obs(), V_DTLH); end
    end
    bus.ls_sns_i = 1'b0;
    step();
    tests++; if (obs() !== V_HS) begin fails++; $display("FAIL sns_release got %b want %b", obs(), V_HS); end
    bus.en_i = 1'b0; step(); bus.en_i = 1'b1; bus.pwm_i = 1'b0; step();
  endtask

  task automatic test_sense_timeout();
    bus.pwm_i = 1'b1; bus.ls_sns_i = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) step();
    tests++; if (obs() !== V_DTLH) begin fails++; $display("FAIL tmo_pre got %b want %b", obs(), V_DTLH); end
    step();
    tests++; if (obs() !== V_FLT) begin fails++; $display("FAIL tmo_fault got %b want %b", obs(), V_FLT); end
    bus.ls_sns_i = 1'b0; bus.pwm_i = 1'b0;
    step();
    tests++; if (obs() !== V_FLT) begin fails++; $display("FAIL tmo_sticky got %b want %b", obs(), V_FLT); end
    bus.en_i = 1'b0;
    step();
    tests++; if (obs() !== V_IDLE) begin fails++; $display("FAIL tmo_clear got %b want %b", obs(), V_IDLE); end
    bus.en_i = 1'b1;
    step();
  endtask

  task automatic test_ls_on_fault();
    bus.hs_sns_i = 1'b1;
    step();
    tests++; if (obs() !== V_FLT) begin fails++; $display("FAIL ls_fault got %b want %b", obs(), V_FLT); end
    bus.hs_sns_i = 1'b0;
    bus.en_i = 1'b0;
    step();
    tests++; if (obs() !== V_IDLE) begin fails++; $display("FAIL ls_fault_clear got %b want %b", obs(), V_IDLE); end
    bus.en_i = 1'b1;
    step();
    tests++; if (obs() !== V_LS) begin fails++; $display("FAIL ls_fault_restart got %b want %b", obs(), V_LS); end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_deadtime_lh();
    test_dthl_pwm_pulse();
    test_reset_mid_deadtime();
    test_en_drop();
`ifdef LOOP_SENSE_CHECK_EN
    test_sense_wait();
    test_sense_timeout();
    test_ls_on_fault();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/loop_nonoverlap_ctrl.md
LOOP_NONOVERLAP_CTRL -- requirements
Module: loop_nonoverlap_ctrl

Interface
REQ-001 SHALL have parameter DEAD_CYC, default 4, minimum dead time in CELCLK cycles (legal 1..255; 0 treated as 1).
REQ-002 SHALL have parameter SNS_TMO, default 16, sense-handshake timeout in cycles (legal DEAD_CYC+1..255).
REQ-003 SHALL have port CELCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port CELRST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have ports CELV, CELG, SUB  input  1 each  supply, ground and substrate pins; no logic function.
REQ-006 SHALL have port en_i  input  1  controller enable.
REQ-007 SHALL have port pwm_i  input  1  switch command: 1 = high side on, 0 = low side on.
REQ-008 SHALL have ports hs_sns_i, ls_sns_i  input  1 each  driver feedback: 1 = that gate is actually high.
REQ-009 SHALL have ports hs_o, ls_o  output  1 each  registered high-side and low-side gate enables.
REQ-010 SHALL have port fault_o  output  1  registered sticky fault flag.
REQ-011 SHALL have port state_o  output  3  current state encoding.

Function
REQ-012 SHALL implement states IDLE=0, LS_ON=1, DT_LH=2, HS_ON=3, DT_HL=4, FAULT=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-013 SHALL decode outputs from registered state only: hs_o=1 only in HS_ON; ls_o=1 only in LS_ON; hs_o and ls_o SHALL never both be 1.
REQ-014 IDLE: both gates off; en_i=1 -> LS_ON (bootstrap charge first).
REQ-015 LS_ON: pwm_i=1 -> DT_LH; 8-bit dead counter cleared on entry.
REQ-016 DT_LH: both gates off; counter increments each cycle; exit to HS_ON once counter reached DEAD_CYC and the sense condition (REQ-024) holds.
REQ-017 HS_ON: pwm_i=0 -> DT_HL; DT_HL mirrors DT_LH and exits to LS_ON.
REQ-018 A dead-time phase, once entered, SHALL complete; pwm_i changes during DT_* SHALL be ignored, then re-evaluated in the following ON state.
REQ-019 Latency: pwm_i change -> active gate off 1 cycle after the sampling edge; opposite gate on no earlier than DEAD_CYC+1 cycles after that edge.
REQ-020 en_i=0 in any state except FAULT SHALL force IDLE on the next edge, overriding all other transitions.
REQ-021 Dead counter SHALL saturate at 255 and never wrap.
REQ-022 pwm_i, en_i and sense inputs SHALL be treated as synchronous; synchronisers lie outside this block.

Reset
REQ-023 CELRST=1 SHALL immediately force state IDLE, hs_o=0, ls_o=0, fault_o=0, counter=0, state_o=0, including mid-dead-time; first transition SHALL occur on the first CELCLK edge after deassertion.

Configuration
REQ-024 Macro LOOP_SENSE_CHECK_EN defined: DT_LH exit additionally requires ls_sns_i=0 (DT_HL requires hs_sns_i=0); counter reaching SNS_TMO without that -> FAULT; in HS_ON, ls_sns_i=1 -> FAULT; in LS_ON, hs_sns_i=1 -> FAULT.
REQ-025 With the macro defined, FAULT SHALL turn both gates off and set fault_o=1; fault_o SHALL stay set until en_i=0 is sampled, which SHALL move to IDLE and clear fault_o.
REQ-026 Macro undefined: sense inputs ignored; dead time exactly DEAD_CYC cycles; FAULT unreachable; fault_o constant 0.

Verification
REQ-027 Reset, en_i=1, pwm_i=0 -> LS_ON 1 cycle after first edge, ls_o=1, hs_o=0, state_o=1.
REQ-028 DEAD_CYC=4, macro off, pwm_i 0->1 in LS_ON -> ls_o=0 next cycle, hs_o=1 exactly 5 cycles after the sampling edge.
REQ-029 Macro on, DEAD_CYC=4, SNS_TMO=16, ls_sns_i held 1 for 8 cycles after pwm_i rises -> hs_o rises 1 cycle after ls_sns_i falls; ls_sns_i stuck 1 -> FAULT at count 16, fault_o=1, both gates off.
REQ-030 pwm_i pulsed 1 for 2 cycles inside DT_HL -> DT_HL completes to LS_ON, no hs_o pulse.
REQ-031 CELRST asserted at count 2 of DT_LH -> all outputs 0 within the same cycle; en_i=0 from HS_ON -> IDLE next edge, hs_o=0.
REQ-032 Macro on, hs_sns_i=1 during LS_ON -> FAULT; en_i=0 for 1 cycle -> IDLE, fault_o=0; en_i=1 -> LS_ON.
